// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline.
// Drives register enables/clears, E-stage forwarding and perf counters.
module pipeline_hazard_ctrl #(
    parameter int RESET_FILL = 2,
    parameter int MAX_WAIT   = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic             RegWriteE,
    input  logic             MemReadE,
    input  logic             PCSrcE,
    input  logic [4:0]       rdM,
    input  logic             RegWriteM,
    input  logic [4:0]       rdW,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             enF,
    output logic             enD,
    output logic             enE,
    output logic             enM,
    output logic             clrD,
    output logic             clrE,
    output logic             clrW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             err
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
    localparam logic [3:0]    FILL_LAST = 4'(RESET_FILL - 1);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_DWAIT} state_t;

    state_t         state;
    logic [3:0]     fill_cnt;
    logic [WW-1:0]  wait_cnt;
    logic           dstall;
    logic           load_use;
    logic           flush;

    always_comb begin
        load_use = MemReadE && RegWriteE && (rdE != 5'd0) &&
                   ((rdE == rs1D) || (rdE == rs2D));
        // M is frozen while waiting, so the pending request is implied
        dstall = !dmem_ready && (MemReqM || (state == S_DWAIT));
        flush = 1'b0;
        enF = 1'b1;
        enD = 1'b1;
        enE = 1'b1;
        enM = 1'b1;
        clrD = 1'b0;
        clrE = 1'b0;
        clrW = 1'b0;
        if (!n_rst || (state == S_INIT)) begin
            enF = 1'b0;
            enD = 1'b0;
            enE = 1'b0;
            enM = 1'b0;
            clrD = 1'b1;
            clrE = 1'b1;
            clrW = 1'b1;
        end else if (dstall) begin
            enF = 1'b0;
            enD = 1'b0;
            enE = 1'b0;
            enM = 1'b0;
            clrW = 1'b1;
        end else if (PCSrcE) begin
            clrD = 1'b1;
            clrE = 1'b1;
            flush = 1'b1;
        end else if (load_use) begin
            enF = 1'b0;
            enD = 1'b0;
            clrE = 1'b1;
        end else if (!imem_ready) begin
            enF = 1'b0;
            clrD = 1'b1;
        end
    end

    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (rdM != 5'd0) && (rdM == rs1E))
            ForwardAE = 2'b10;
        else if (RegWriteW && (rdW != 5'd0) && (rdW == rs1E))
            ForwardAE = 2'b01;
        ForwardBE = 2'b00;
        if (RegWriteM && (rdM != 5'd0) && (rdM == rs2E))
            ForwardBE = 2'b10;
        else if (RegWriteW && (rdW != 5'd0) && (rdW == rs2E))
            ForwardBE = 2'b01;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= S_INIT;
            fill_cnt <= 4'd0;
            wait_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            err <= 1'b0;
        end else begin
            if (state != S_INIT) begin
                if (!enF && (stall_cnt != '1))
                    stall_cnt <= stall_cnt + CNT_W'(1);
                if (flush && (flush_cnt != '1))
                    flush_cnt <= flush_cnt + CNT_W'(1);
            end
            case (state)
                S_INIT: begin
                    fill_cnt <= fill_cnt + 4'd1;
                    if (fill_cnt == FILL_LAST)
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (dstall) begin
                        state <= S_DWAIT;
                        wait_cnt <= WW'(1);
                        if (WAIT_MAX == WW'(1))
                            err <= 1'b1;
                    end
                end
                S_DWAIT: begin
                    if (dmem_ready) begin
                        state <= S_RUN;
                    end else if (wait_cnt != WAIT_MAX) begin
                        wait_cnt <= wait_cnt + WW'(1);
                        if (wait_cnt + WW'(1) == WAIT_MAX)
                            err <= 1'b1;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed steps then random stimulus
// checked against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int RF  = 2;
    localparam int MW  = 4;
    localparam int CW  = 8;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          n_rst;
    logic [4:0]    rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic          RegWriteE, MemReadE, PCSrcE, RegWriteM, RegWriteW;
    logic          MemReqM, imem_ready, dmem_ready;
    logic          enF, enD, enE, enM, clrD, clrE, clrW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic          err;

    int total = 0;
    int bad = 0;

    // model state: 0 fill, 1 run, 2 waiting on dmem
    int m_mode;
    int m_fill;
    int m_wait;
    int m_stall;
    int m_flush;
    bit m_err;
    logic [6:0] e_ctl;
    bit e_flush;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .RESET_FILL(RF),
        .MAX_WAIT(MW),
        .CNT_W(CW)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .rs1D(rs1D), .rs2D(rs2D),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .RegWriteE(RegWriteE), .MemReadE(MemReadE),
        .PCSrcE(PCSrcE),
        .rdM(rdM), .RegWriteM(RegWriteM),
        .rdW(rdW), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .enF(enF), .enD(enD), .enE(enE), .enM(enM),
        .clrD(clrD), .clrE(clrE), .clrW(clrW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (RegWriteM && rdM != 0 && rdM == rs) return 2'b10;
        if (RegWriteW && rdW != 0 && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // control vector order: enF enD enE enM clrD clrE clrW
    task automatic predict();
        bit lu;
        bit ds;
        lu = MemReadE && RegWriteE && rdE != 0 &&
             (rdE == rs1D || rdE == rs2D);
        ds = !dmem_ready && (MemReqM || m_mode == 2);
        e_flush = 0;
        if (!n_rst || m_mode == 0) e_ctl = 7'b0000111;
        else if (ds) e_ctl = 7'b0000001;
        else if (PCSrcE) begin
            e_ctl = 7'b1111110;
            e_flush = 1;
        end
        else if (lu) e_ctl = 7'b0011010;
        else if (!imem_ready) e_ctl = 7'b0111100;
        else e_ctl = 7'b1111000;
    endtask

    task automatic model_edge();
        bit ds;
        ds = !dmem_ready && (MemReqM || m_mode == 2);
        if (!n_rst) begin
            m_mode = 0;
            m_fill = 0;
            m_wait = 0;
            m_stall = 0;
            m_flush = 0;
            m_err = 0;
        end else if (m_mode == 0) begin
            if (m_fill == RF - 1) m_mode = 1;
            m_fill++;
        end else begin
            if (!e_ctl[6] && m_stall < SAT) m_stall++;
            if (e_flush && m_flush < SAT) m_flush++;
            if (m_mode == 1) begin
                if (ds) begin
                    m_mode = 2;
                    m_wait = 1;
                    if (m_wait >= MW) m_err = 1;
                end
            end else if (dmem_ready) begin
                m_mode = 1;
            end else begin
                if (m_wait < MW) m_wait++;
                if (m_wait >= MW) m_err = 1;
            end
        end
    endtask

    task automatic step();
        #2;
        predict();
        chk("ctl", 32'({enF, enD, enE, enM, clrD, clrE, clrW}),
            32'(e_ctl));
        chk("fwdA", 32'(ForwardAE), 32'(fwd(rs1E)));
        chk("fwdB", 32'(ForwardBE), 32'(fwd(rs2E)));
        @(posedge clk);
        model_edge();
        #1;
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic idle();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0;
        rdM = 0; rdW = 0;
        RegWriteE = 0; MemReadE = 0; PCSrcE = 0;
        RegWriteM = 0; RegWriteW = 0; MemReqM = 0;
        imem_ready = 1; dmem_ready = 1;
    endtask

    initial begin
        m_mode = 0; m_fill = 0; m_wait = 0;
        m_stall = 0; m_flush = 0; m_err = 0;
        idle();
        n_rst = 0;
        @(posedge clk);
        #1;
        // reset held, then fill
        repeat (3) step();
        n_rst = 1;
        repeat (RF + 2) step();
        chk("run_after_fill", 32'({enF, clrD}), 32'(2'b10));

        // load-use
        MemReadE = 1; RegWriteE = 1; rdE = 5; rs1D = 5;
        step();
        MemReadE = 0; RegWriteE = 0; rdE = 0;
        step();
        chk("lu_stall1", 32'(stall_cnt), 32'(1));

        // branch beats load-use and imem wait
        MemReadE = 1; RegWriteE = 1; rdE = 5; rs1D = 5;
        PCSrcE = 1; imem_ready = 0;
        step();
        idle();
        step();

        // short dmem wait, no error
        MemReqM = 1; dmem_ready = 0;
        repeat (3) step();
        dmem_ready = 1;
        step();
        MemReqM = 0;
        step();

        // long dmem wait sets sticky err
        MemReqM = 1; dmem_ready = 0;
        repeat (10) step();
        chk("err_set", 32'(err), 32'(1));
        dmem_ready = 1;
        step();
        MemReqM = 0;
        step();
        chk("err_sticky", 32'(err), 32'(1));

        // reset mid-wait
        MemReqM = 1; dmem_ready = 0;
        repeat (2) step();
        n_rst = 0;
        step();
        chk("err_cleared", 32'(err), 32'(0));
        n_rst = 1;
        idle();
        repeat (RF + 1) step();

        // forwarding priority
        rs1E = 7; rs2E = 7; rdM = 7; rdW = 7;
        RegWriteM = 1; RegWriteW = 1;
        step();
        chk("fwdA_M", 32'(ForwardAE), 32'(2'b10));
        RegWriteM = 0;
        step();
        chk("fwdA_W", 32'(ForwardAE), 32'(2'b01));
        rdM = 0; rdW = 0;
        step();
        chk("fwdA_RF", 32'(ForwardAE), 32'(2'b00));

        // random phase
        for (int i = 0; i < 4000; i++) begin
            n_rst = ($urandom_range(0, 299) != 0);
            rs1D = 5'($urandom_range(0, 3));
            rs2D = 5'($urandom_range(0, 3));
            rs1E = 5'($urandom_range(0, 3));
            rs2E = 5'($urandom_range(0, 3));
            rdE = 5'($urandom_range(0, 3));
            rdM = 5'($urandom_range(0, 3));
            rdW = 5'($urandom_range(0, 3));
            RegWriteE = 1'($urandom);
            MemReadE = 1'($urandom);
            RegWriteM = 1'($urandom);
            RegWriteW = 1'($urandom);
            PCSrcE = ($urandom_range(0, 99) < 15);
            MemReqM = ($urandom_range(0, 99) < 40);
            imem_ready = ($urandom_range(0, 99) < 85);
            dmem_ready = ($urandom_range(0, 99) < 75);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
